fdivsqrt_seq_ctrl: RTL and testbench
====================================

Name: fdivsqrt_seq_ctrl

Overview:
- Iteration sequencer for the shared divide/square-root unit, covering FP div, FP sqrt and integer div/rem.
- Accepts a start from the Execute stage and pulses the initial-residual load.
- Enables the recurrence step for a programmed number of cycles, and ends early on an exact (zero-residual) result.
- Holds completion while Memory stalls, and tracks the special-case flag into M for the postprocessor.

Parameters:
- CNTW, 7, width of the iteration counter and CyclesE (must hold the max cycle count, e.g. DIVb/LOGR + setup).
- EARLYTERM, 1, 1 = terminate when WZeroE asserts during iteration; 0 = always run the full count.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- FDivStartE  input  1  FP div/sqrt op valid in E
- IDivStartE  input  1  integer div/rem op valid in E
- SpecialCaseE  input  1  result needs no iteration (NaN/Inf/zero operand, int divide-by-zero, |A|<|B|)
- CyclesE  input  CNTW  recurrence cycles required for this op
- WZeroE  input  1  residual-is-zero from the datapath, valid while iterating
- StallM  input  1  Memory stage stalled
- FlushE  input  1  kill the operation in E
- IFDivStartE  output  1  one-cycle pulse; load operands/initial residual
- StepE  output  1  advance the recurrence (residual/quotient registers enable)
- FDivBusyE  output  1  stall request to the pipeline
- FDivDoneE  output  1  result available for capture into M
- SpecialCaseM  output  1  registered SpecialCaseE of the current op
- CycleCntE  output  CNTW  remaining iterations (debug/verification)

Behaviour:
- States: IDLE, BUSY, DONE, held in a single state register.
- Reset (synchronous, active-high):
  - state=IDLE, CycleCntE=0, SpecialCaseM=0.
  - All combinational outputs are derived from state, so all outputs are 0 in the cycle after reset.
- Start (combinational): IFDivStartE = IDLE & (FDivStartE | IDivStartE) & ~FlushE. Both starts high counts as a single start.
- IDLE, on IFDivStartE:
  - SpecialCaseM <= SpecialCaseE.
  - If SpecialCaseE: next state DONE, no iteration.
  - Otherwise: next state BUSY, and CycleCntE <= CyclesE. CyclesE=0 is treated as 1.
- IDLE without a start: state and counter hold.
- BUSY:
  - StepE=1, FDivBusyE=1, and CycleCntE decrements once per cycle.
  - Exit to DONE when CycleCntE==1 (gives exactly CyclesE StepE cycles), or when EARLYTERM & WZeroE.
  - When both exit conditions hold, go to DONE (single exit, no double count).
- DONE:
  - FDivDoneE=1, StepE=0, and FDivBusyE = StallM.
  - ~StallM: next state IDLE, so Done is a one-cycle pulse when M is not stalled.
  - StallM: stay in DONE, with Done and Busy both held high.
- FlushE:
  - In BUSY or DONE, FlushE forces next state IDLE, CycleCntE <= 0, no FDivDoneE the following cycle.
  - FlushE has priority over exit and early-termination conditions.
  - FlushE with a start in IDLE suppresses the start entirely.
- SpecialCaseM changes only on IFDivStartE and is stable throughout BUSY and DONE.
- WZeroE is ignored outside BUSY.
- StallM is ignored in IDLE and BUSY; iteration proceeds regardless.
- No back-to-back starts: a new start is accepted only in IDLE, i.e. at the earliest one cycle after a DONE exit.
- Latency, start to FDivDoneE:
  - Normal op: CyclesE+1 cycles.
  - Special case: 1 cycle.
  - Early-terminated op: k+1 cycles, where k is the BUSY cycle in which WZeroE was seen.

Test Plan:
- Reset then FDivStartE=1, CyclesE=5, WZeroE=0, StallM=0 -> IFDivStartE pulse in cycle 0; StepE high cycles 1-5 with CycleCntE 5,4,3,2,1; FDivDoneE cycle 6 only; IDLE cycle 7.
- IDivStartE=1, CyclesE=20, EARLYTERM=1, WZeroE asserted in 3rd BUSY cycle -> exactly 3 StepE cycles, FDivDoneE next cycle. With EARLYTERM=0, same stimulus -> 20 StepE cycles.
- FDivStartE=1, SpecialCaseE=1 -> no StepE; FDivDoneE one cycle after start; SpecialCaseM=1 held until the next start, then 0 for a normal op.
- CyclesE=2, StallM high for 3 cycles starting at DONE -> FDivDoneE and FDivBusyE high for 3 cycles, IDLE after StallM drops; no StepE during DONE.
- FlushE asserted in 2nd BUSY cycle of a CyclesE=10 op -> IDLE next cycle, CycleCntE=0, no FDivDoneE. Start+FlushE in IDLE -> no IFDivStartE.
- Reset asserted mid-BUSY (CycleCntE=4) -> next cycle IDLE, all outputs 0. CyclesE=0 start -> exactly 1 StepE cycle.

Source files
------------

// File: rtl/fdivsqrt_seq_ctrl_if.sv
// Handshake bundle between the Execute/Memory pipeline control and the
// divide/sqrt iteration sequencer.
interface fdivsqrt_seq_ctrl_if #(
  parameter int CNTW = 7
);
  logic            FDivStartE;
  logic            IDivStartE;
  logic            SpecialCaseE;
  logic [CNTW-1:0] CyclesE;
  logic            WZeroE;
  logic            StallM;
  logic            FlushE;

  logic            IFDivStartE;
  logic            StepE;
  logic            FDivBusyE;
  logic            FDivDoneE;
  logic            SpecialCaseM;
  logic [CNTW-1:0] CycleCntE;

  // Pipeline side: issues ops, observes sequencer status.
  modport master (
    output FDivStartE, IDivStartE, SpecialCaseE, CyclesE, WZeroE, StallM, FlushE,
    input  IFDivStartE, StepE, FDivBusyE, FDivDoneE, SpecialCaseM, CycleCntE
  );

  // Sequencer side.
  modport slave (
    input  FDivStartE, IDivStartE, SpecialCaseE, CyclesE, WZeroE, StallM, FlushE,
    output IFDivStartE, StepE, FDivBusyE, FDivDoneE, SpecialCaseM, CycleCntE
  );
endinterface

// File: rtl/fdivsqrt_seq_ctrl.sv
// Iteration sequencer for the shared FP div/sqrt and integer div/rem unit:
// start pulse, counted recurrence steps with optional early exit, stall-aware done.
module fdivsqrt_seq_ctrl #(
  parameter int CNTW      = 7,
  parameter bit EARLYTERM = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  fdivsqrt_seq_ctrl_if.slave         io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            spec_q, spec_d;

  logic start, step, busy, done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      spec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      spec_q  <= spec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    spec_d  = spec_q;
    start   = 1'b0;
    step    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        start = (io.FDivStartE | io.IDivStartE) & ~io.FlushE;
        if (start) begin
          spec_d = io.SpecialCaseE;
          if (io.SpecialCaseE) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            // A zero cycle request still performs one recurrence step.
            cnt_d   = (io.CyclesE == '0) ? CNT_ONE : io.CyclesE;
          end
        end
      end

      BUSY: begin
        step  = 1'b1;
        busy  = 1'b1;
        cnt_d = cnt_q - CNT_ONE;
        if (io.FlushE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if ((cnt_q <= CNT_ONE) || (EARLYTERM && io.WZeroE)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done = 1'b1;
        busy = io.StallM;
        if (io.FlushE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!io.StallM) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign io.IFDivStartE  = start;
  assign io.StepE        = step;
  assign io.FDivBusyE    = busy;
  assign io.FDivDoneE    = done;
  assign io.SpecialCaseM = spec_q;
  assign io.CycleCntE    = cnt_q;

endmodule

// File: tb/tb_fdivsqrt_seq_ctrl.sv
// Scoreboard bench: two sequencers (early termination on/off) share one
// stimulus stream; per-op expectations come from a cycle-count model.
module tb_fdivsqrt_seq_ctrl;

  localparam int CNTW = 7;

  logic            clk;
  logic            rst;
  logic            fdiv_s, idiv_s, spec_s, wz_s, stall_s, flush_s;
  logic [CNTW-1:0] cyc_s;

  fdivsqrt_seq_ctrl_if #(.CNTW(CNTW)) if0 ();
  fdivsqrt_seq_ctrl_if #(.CNTW(CNTW)) if1 ();

  assign if0.FDivStartE = fdiv_s;   assign if1.FDivStartE = fdiv_s;
  assign if0.IDivStartE = idiv_s;   assign if1.IDivStartE = idiv_s;
  assign if0.SpecialCaseE = spec_s; assign if1.SpecialCaseE = spec_s;
  assign if0.CyclesE = cyc_s;       assign if1.CyclesE = cyc_s;
  assign if0.WZeroE = wz_s;         assign if1.WZeroE = wz_s;
  assign if0.StallM = stall_s;      assign if1.StallM = stall_s;
  assign if0.FlushE = flush_s;      assign if1.FlushE = flush_s;

  fdivsqrt_seq_ctrl #(.CNTW(CNTW), .EARLYTERM(1'b1)) dut0 (.clk(clk), .reset(rst), .io(if0));
  fdivsqrt_seq_ctrl #(.CNTW(CNTW), .EARLYTERM(1'b0)) dut1 (.clk(clk), .reset(rst), .io(if1));

  logic [1:0]      o_start, o_step, o_busy, o_done, o_spec;
  logic [CNTW-1:0] o_cnt [2];
  assign o_start = {if1.IFDivStartE, if0.IFDivStartE};
  assign o_step  = {if1.StepE, if0.StepE};
  assign o_busy  = {if1.FDivBusyE, if0.FDivBusyE};
  assign o_done  = {if1.FDivDoneE, if0.FDivDoneE};
  assign o_spec  = {if1.SpecialCaseM, if0.SpecialCaseM};
  assign o_cnt[0] = if0.CycleCntE;
  assign o_cnt[1] = if1.CycleCntE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int steps;
    int dones;
    int busy;
    int lat;
    int fc;
    int endc;
    int spec;
    int spec_ok;
  } rec_t;

  rec_t exp0_q[$];
  rec_t exp1_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fin_cnt [2];

  task automatic chk(input string nm, input int d, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s dut%0d got %0d expected %0d", nm, d, act, expv);
    end
  endtask

  // Length of the StallM run beginning at cycle t0 of the op.
  function automatic int stall_run(input int t0, input int ss, input int sl);
    if (ss >= 0 && t0 >= ss && t0 < ss + sl) return ss + sl - t0;
    return 0;
  endfunction

  // Expected observable summary of one op for the sequencer with/without early exit.
  function automatic rec_t model(input int d, input bit sp, input int c, input int wz,
                                 input int ss, input int sl, input int fl);
    rec_t r;
    int   n;
    int   dl;
    n         = (c == 0) ? 1 : c;
    r.spec    = sp;
    r.spec_ok = 1;
    if (sp) begin
      dl      = 1 + stall_run(1, ss, sl);
      r.steps = 0;  r.dones = dl;  r.busy = dl - 1;
      r.lat   = 1;  r.fc = -1;     r.endc = -1;
    end else if (fl >= 1) begin
      r.steps = fl; r.dones = 0;   r.busy = fl;
      r.lat   = -1; r.fc = n;      r.endc = 0;
    end else begin
      r.steps = (d == 0 && wz >= 1 && wz <= n) ? wz : n;
      dl      = 1 + stall_run(r.steps + 1, ss, sl);
      r.dones = dl;
      r.busy  = r.steps + dl - 1;
      r.lat   = r.steps + 1;
      r.fc    = n;
      r.endc  = n - r.steps;
    end
    return r;
  endfunction

  // Monitor: tracks each DUT from its start pulse to its return to idle.
  bit   trk [2];
  int   t_m [2];
  rec_t act_m [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        trk[d] = 1'b0;
      end else if (!trk[d]) begin
        if (o_start[d] === 1'b1) begin
          trk[d]   = 1'b1;
          t_m[d]   = 0;
          act_m[d] = '{0, 0, 0, -1, -1, -1, 0, 1};
        end
      end else begin
        t_m[d]++;
        if (t_m[d] == 1) act_m[d].spec = int'(o_spec[d]);
        else if (int'(o_spec[d]) != act_m[d].spec) act_m[d].spec_ok = 0;
        if (o_step[d] !== 1'b1 && o_done[d] !== 1'b1) begin
          rec_t e;
          bit   have;
          act_m[d].endc = int'(o_cnt[d]);
          have = 1'b0;
          if (d == 0 && exp0_q.size() > 0) begin e = exp0_q.pop_front(); have = 1'b1; end
          if (d == 1 && exp1_q.size() > 0) begin e = exp1_q.pop_front(); have = 1'b1; end
          if (!have) begin
            chk("unexpected_op", d, 1, 0);
          end else begin
            chk("step_cycles", d, act_m[d].steps, e.steps);
            chk("done_cycles", d, act_m[d].dones, e.dones);
            chk("busy_cycles", d, act_m[d].busy, e.busy);
            chk("done_latency", d, act_m[d].lat, e.lat);
            chk("special_m", d, act_m[d].spec, e.spec);
            chk("special_m_stable", d, act_m[d].spec_ok, e.spec_ok);
            if (e.fc >= 0) chk("first_count", d, act_m[d].fc, e.fc);
            if (e.endc >= 0) chk("end_count", d, act_m[d].endc, e.endc);
          end
          trk[d] = 1'b0;
          fin_cnt[d]++;
        end else begin
          if (o_step[d] === 1'b1) begin
            act_m[d].steps++;
            if (act_m[d].steps == 1) act_m[d].fc = int'(o_cnt[d]);
          end
          if (o_done[d] === 1'b1) begin
            act_m[d].dones++;
            if (act_m[d].lat < 0) act_m[d].lat = t_m[d];
          end
          if (o_busy[d] === 1'b1) act_m[d].busy++;
        end
      end
    end
  end

  task automatic idle_inputs();
    fdiv_s = 0; idiv_s = 0; spec_s = 0; wz_s = 0; stall_s = 0; flush_s = 0; cyc_s = '0;
  endtask

  // wz/ss/fl < 0 mean "not used"; times are cycles after the start cycle.
  task automatic run_op(input bit idiv, input bit sp, input int c, input int wz,
                        input int ss, input int sl, input int fl);
    int  b0, b1;
    bit  fin;
    exp0_q.push_back(model(0, sp, c, wz, ss, sl, fl));
    exp1_q.push_back(model(1, sp, c, wz, ss, sl, fl));
    b0  = fin_cnt[0];
    b1  = fin_cnt[1];
    fin = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      if (fin_cnt[0] != b0 && fin_cnt[1] != b1) begin
        fin = 1'b1;
        break;
      end
      fdiv_s  = (t == 0) && !idiv;
      idiv_s  = (t == 0) && idiv;
      spec_s  = (t == 0) ? sp : 1'($urandom);
      cyc_s   = (t == 0) ? CNTW'(c) : CNTW'($urandom);
      wz_s    = (t == wz);
      flush_s = (t == fl);
      stall_s = (ss >= 0 && t >= ss && t < ss + sl);
    end
    idle_inputs();
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL op_timeout got running expected finished within 400 cycles");
    end
  endtask

  initial begin
    fin_cnt[0] = 0;
    fin_cnt[1] = 0;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_outputs", d, int'({o_start[d], o_step[d], o_busy[d], o_done[d], o_spec[d]}), 0);
      chk("reset_count", d, int'(o_cnt[d]), 0);
    end

    run_op(1'b0, 1'b0, 5, -1, -1, 0, -1);
    run_op(1'b1, 1'b0, 20, 3, -1, 0, -1);
    run_op(1'b0, 1'b1, 9, -1, -1, 0, -1);
    run_op(1'b0, 1'b0, 4, -1, -1, 0, -1);
    run_op(1'b0, 1'b0, 2, -1, 3, 3, -1);
    run_op(1'b0, 1'b0, 10, -1, -1, 0, 2);
    run_op(1'b0, 1'b0, 0, -1, -1, 0, -1);
    run_op(1'b1, 1'b1, 3, -1, 1, 2, -1);
    run_op(1'b0, 1'b0, 127, 60, -1, 0, -1);

    for (int i = 0; i < 40; i++) begin
      int  c, n, mode, wz, ss, sl, fl;
      bit  sp, id;
      id   = 1'($urandom);
      sp   = ($urandom_range(0, 5) == 0);
      c    = $urandom_range(0, 24);
      n    = (c == 0) ? 1 : c;
      mode = $urandom_range(0, 3);
      wz = -1; ss = -1; sl = 0; fl = -1;
      if (mode == 1 || mode == 3) wz = $urandom_range(1, n + 2);
      if (mode == 2 && !sp) fl = $urandom_range(1, n);
      if (mode == 3 || (mode == 0 && sp)) begin
        ss = $urandom_range(1, n + 3);
        sl = $urandom_range(1, 4);
      end
      run_op(id, sp, c, wz, ss, sl, fl);
    end

    // Start together with flush in IDLE must not be accepted.
    @(posedge clk); #1;
    fdiv_s = 1; idiv_s = 1; flush_s = 1; cyc_s = 7'd6;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("flush_blocks_start", d, int'(o_start[d]), 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("no_busy_after_blocked", d, int'({o_step[d], o_busy[d]}), 0);

    // Reset in the middle of an iteration, when 4 steps remain.
    @(posedge clk); #1;
    fdiv_s = 1; cyc_s = 7'd10;
    @(posedge clk); #1;
    idle_inputs();
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("count_before_reset", d, int'(o_cnt[d]), 4);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("midbusy_reset_outputs", d, int'({o_start[d], o_step[d], o_busy[d], o_done[d], o_spec[d]}), 0);
      chk("midbusy_reset_count", d, int'(o_cnt[d]), 0);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 0, exp0_q.size(), 0);
    chk("scoreboard_empty", 1, exp1_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
